// File: rtl/bist_fail_log.sv
// BIST failure logger: captures read-phase compare mismatches into a small FIFO of {addr, exp, syndrome}.
// Optional: define BIST_FAIL_LOG_COUNT_EN to add a saturating 16-bit fail_count output.
module bist_fail_log #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bist_active,
  input  logic              clr,
  input  logic              cmp_valid,
  input  logic [ADDR_W-1:0] cmp_addr,
  input  logic [DATA_W-1:0] cmp_exp,
  input  logic [DATA_W-1:0] cmp_act,
  input  logic              log_ready,
  output logic              log_valid,
  output logic [ADDR_W-1:0] log_addr,
  output logic [DATA_W-1:0] log_exp,
  output logic [DATA_W-1:0] log_syn,
  output logic              full,
  output logic              empty,
  output logic              overflow,
`ifdef BIST_FAIL_LOG_COUNT_EN
  output logic [15:0]       fail_count,
`endif
  output logic              busy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned REC_W = ADDR_W + 2 * DATA_W;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     count, count_nxt;
  logic [REC_W-1:0]   mem [DEPTH];
  logic [REC_W-1:0]   rec_in;
  logic               mismatch, push, pop, drop;

  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  assign log_valid = !empty;
  assign busy      = (state != IDLE);

  assign {log_addr, log_exp, log_syn} = mem[rd_ptr];
  assign rec_in = {cmp_addr, cmp_exp, cmp_exp ^ cmp_act};

  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign mismatch = (state == CAPTURE) && cmp_valid && (cmp_exp != cmp_act);
  assign pop      = log_valid && log_ready;
  assign push     = mismatch && (!full || pop);
  assign drop     = mismatch && full && !pop;

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + 1'b1;
    else if (pop && !push)
      count_nxt = count - 1'b1;
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bist_active) state_nxt = CAPTURE;
        CAPTURE: if (!bist_active) state_nxt = empty ? IDLE : DRAIN;
        DRAIN: begin
          if (bist_active)
            state_nxt = CAPTURE;
          else if (count_nxt == '0)
            state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (!clr && push) begin
      mem[wr_ptr] <= rec_in;
    end
  end

`ifdef BIST_FAIL_LOG_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fail_count <= '0;
    else if (clr)
      fail_count <= '0;
    else if (mismatch && (fail_count != '1))
      fail_count <= fail_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_bist_fail_log.sv
// Scoreboard bench for bist_fail_log: expected records are queued at issue time and
// checked by a monitor on every accepted handshake; status outputs checked directly.
module tb_bist_fail_log;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned REC_W  = ADDR_W + 2 * DATA_W;

  logic              clk = 1'b0;
  logic              rst, bist_active, clr, cmp_valid, log_ready;
  logic [ADDR_W-1:0] cmp_addr;
  logic [DATA_W-1:0] cmp_exp, cmp_act;
  logic              log_valid, full, empty, overflow, busy;
  logic [ADDR_W-1:0] log_addr;
  logic [DATA_W-1:0] log_exp, log_syn;
`ifdef BIST_FAIL_LOG_COUNT_EN
  logic [15:0]       fail_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [REC_W-1:0] exp_q [$];

  bist_fail_log #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bist_active(bist_active), .clr(clr),
    .cmp_valid(cmp_valid), .cmp_addr(cmp_addr), .cmp_exp(cmp_exp), .cmp_act(cmp_act),
    .log_ready(log_ready), .log_valid(log_valid), .log_addr(log_addr),
    .log_exp(log_exp), .log_syn(log_syn), .full(full), .empty(empty),
    .overflow(overflow),
`ifdef BIST_FAIL_LOG_COUNT_EN
    .fail_count(fail_count),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input logic v, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] e, input logic [DATA_W-1:0] x);
    cmp_valid = v;
    cmp_addr  = a;
    cmp_exp   = e;
    cmp_act   = x;
  endtask

  // Monitor: every accepted head record must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && log_valid && log_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_record", {10'd0, log_addr, log_exp, log_syn}, 32'hDEAD);
      end else begin
        chk("record", {10'd0, log_addr, log_exp, log_syn}, {10'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; bist_active = 1'b0; clr = 1'b0; log_ready = 1'b0;
    cmp(1'b0, '0, '0, '0);
    step(); step();
    chk("rst_log_valid", log_valid, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_log_fields", {log_addr, log_exp, log_syn}, 0);
`ifdef BIST_FAIL_LOG_COUNT_EN
    chk("rst_fail_count", fail_count, 0);
`endif
    rst = 1'b0;
    step();

    // Single mismatch: addr 5, exp 55, act 54 -> syndrome 01.
    bist_active = 1'b1;
    step();
    chk("capture_busy", busy, 1);
    cmp(1'b1, 6'd5, 8'h55, 8'h54);
    exp_q.push_back({6'd5, 8'h55, 8'h01});
    step();
    cmp(1'b0, '0, '0, '0);
    chk("first_valid", log_valid, 1);
    chk("first_addr", log_addr, 5);
    chk("first_exp", log_exp, 8'h55);
    chk("first_syn", log_syn, 8'h01);
    log_ready = 1'b1;
    step();
    log_ready = 1'b0;
    chk("first_popped_empty", empty, 1);

    // Matching compares never log.
    for (int i = 0; i < 3; i++) begin
      cmp(1'b1, 6'(i), 8'hAA, 8'hAA);
      step();
    end
    cmp(1'b0, '0, '0, '0);
    chk("match_no_log", log_valid, 0);

    // Back to IDLE; mismatches there, and on the IDLE->CAPTURE edge, are ignored.
    bist_active = 1'b0;
    step();
    chk("idle_busy", busy, 0);
    cmp(1'b1, 6'd7, 8'h0F, 8'hF0);
    step(); step();
    chk("idle_no_log", log_valid, 0);
    bist_active = 1'b1;
    step();
    cmp(1'b0, '0, '0, '0);
    chk("entry_edge_busy", busy, 1);
    chk("entry_edge_no_log", log_valid, 0);

    // clr with bist_active high: IDLE next edge, CAPTURE one later.
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_idle", busy, 0);
`ifdef BIST_FAIL_LOG_COUNT_EN
    chk("clr_fail_count", fail_count, 0);
`endif
    step();
    chk("clr_recapture", busy, 1);

    // Fill to full, then push+pop on a full FIFO, then one dropped record.
    for (int i = 0; i < 4; i++) begin
      cmp(1'b1, 6'(10 + i), 8'(8'hA0 + i), 8'(8'hA0 + i) ^ (8'h01 << i));
      exp_q.push_back({6'(10 + i), 8'(8'hA0 + i), 8'h01 << i});
      step();
    end
    chk("fill_full", full, 1);
    chk("fill_no_overflow", overflow, 0);
    cmp(1'b1, 6'd14, 8'hA4, 8'hA4 ^ 8'h10);
    exp_q.push_back({6'd14, 8'hA4, 8'h10});
    log_ready = 1'b1;
    step();
    log_ready = 1'b0;
    chk("pushpop_full", full, 1);
    chk("pushpop_no_overflow", overflow, 0);
    cmp(1'b1, 6'd15, 8'hA5, 8'hA5 ^ 8'h20);
    step();
    cmp(1'b0, '0, '0, '0);
    chk("drop_full", full, 1);
    chk("drop_overflow", overflow, 1);
`ifdef BIST_FAIL_LOG_COUNT_EN
    chk("drop_fail_count", fail_count, 6);
`endif

    // Pop two while capturing, then drain the remaining two.
    log_ready = 1'b1;
    step(); step();
    log_ready = 1'b0;
    bist_active = 1'b0;
    step();
    chk("drain_busy", busy, 1);
    chk("drain_valid", log_valid, 1);
    log_ready = 1'b1;
    step();
    chk("drain_mid_busy", busy, 1);
    step();
    log_ready = 1'b0;
    chk("drain_done_busy", busy, 0);
    chk("drain_done_empty", empty, 1);
    chk("overflow_sticky", overflow, 1);

    // clr mid-capture with 3 records held.
    bist_active = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      cmp(1'b1, 6'(20 + i), 8'h33, 8'h3C);
      step();
    end
    cmp(1'b0, '0, '0, '0);
    chk("pre_clr_nonempty", empty, 0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("mid_clr_empty", empty, 1);
    chk("mid_clr_overflow", overflow, 0);
    chk("mid_clr_idle", busy, 0);
`ifdef BIST_FAIL_LOG_COUNT_EN
    chk("mid_clr_fail_count", fail_count, 0);
`endif
    step();

    // Async rst mid-capture with overflow set.
    for (int i = 0; i < 5; i++) begin
      cmp(1'b1, 6'(30 + i), 8'h01, 8'h02);
      step();
    end
    cmp(1'b0, '0, '0, '0);
    chk("pre_rst_overflow", overflow, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_idle", busy, 0);
    chk("mid_rst_fields", {log_addr, log_exp, log_syn}, 0);
`ifdef BIST_FAIL_LOG_COUNT_EN
    chk("mid_rst_fail_count", fail_count, 0);
`endif
    step();
    rst = 1'b0;
    step();
    chk("post_rst_capture", busy, 1);
    bist_active = 1'b0;
    step();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bist_fail_log.md
BIST_FAIL_LOG -- requirements
Module: bist_fail_log

Interface
REQ-001 Parameter ADDR_W, default 6, RAM address width.
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 Parameter DEPTH, default 4, number of failure-record entries; SHALL be a power of two and at least 2.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 bist_active  input  1  high while the upstream BIST engine is in test mode.
REQ-007 clr  input  1  synchronous flush of the log.
REQ-008 cmp_valid  input  1  read-phase compare strobe from the upstream BIST.
REQ-009 cmp_addr  input  ADDR_W  address being read.
REQ-010 cmp_exp  input  DATA_W  expected (latched pattern) data.
REQ-011 cmp_act  input  DATA_W  RAM read data.
REQ-012 log_ready  input  1  consumer accepts the head record.
REQ-013 log_valid  output  1  head record available.
REQ-014 log_addr  output  ADDR_W  failing address of the head record.
REQ-015 log_exp  output  DATA_W  expected data of the head record.
REQ-016 log_syn  output  DATA_W  syndrome of the head record (cmp_exp XOR cmp_act).
REQ-017 full / empty  output  1 each  FIFO status.
REQ-018 overflow  output  1  sticky flag: at least one record was dropped.
REQ-019 busy  output  1  high when the state is not IDLE.

Function
REQ-020 A mismatch SHALL be defined as state CAPTURE, cmp_valid=1 and cmp_exp != cmp_act.
- cmp_valid in any other state SHALL be ignored.
REQ-021 FSM states SHALL be IDLE, CAPTURE and DRAIN.
- IDLE -> CAPTURE when bist_active=1.
- CAPTURE -> DRAIN when bist_active=0 and the FIFO is not empty.
- CAPTURE -> IDLE when bist_active=0 and the FIFO is empty.
- DRAIN -> IDLE when the FIFO becomes empty.
- DRAIN -> CAPTURE when bist_active=1.
REQ-022 A mismatch at edge N SHALL be written as {cmp_addr, cmp_exp, cmp_exp^cmp_act}.
- It SHALL appear on the log_* outputs, with log_valid=1, in the cycle after edge N if the FIFO was empty.
REQ-023 log_valid SHALL equal !empty.
- log_* SHALL always present the head entry from registered storage.
REQ-024 A pop SHALL occur on an edge with log_valid && log_ready, in any state.
- log_ready while empty SHALL have no effect.
REQ-025 Mismatch with FIFO full and no pop on the same edge: the record SHALL be dropped and overflow set to 1.
REQ-026 Mismatch and pop on the same edge: both SHALL be performed, including when full.
- Occupancy SHALL be unchanged and overflow SHALL not be set.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.
- The occupancy count SHALL be log2(DEPTH)+1 bits.
- full = (count==DEPTH); empty = (count==0).
REQ-028 clr=1 SHALL take priority over push and pop.
- It SHALL empty the FIFO, clear overflow and force IDLE on the next edge.
- If bist_active is still 1, the FSM SHALL re-enter CAPTURE one cycle later.
REQ-029 overflow SHALL remain set until clr or rst.

Reset
REQ-030 rst=1 SHALL immediately force the state to IDLE and the pointers and count to 0.
- Outputs SHALL be: log_valid=0, empty=1, full=0, overflow=0, busy=0, log_addr/log_exp/log_syn=0.
REQ-031 Reset asserted mid-capture or mid-drain SHALL discard all stored records.
- No push or pop SHALL occur on an edge where rst=1.

Configuration
REQ-032 Macro BIST_FAIL_LOG_COUNT_EN, when defined, SHALL add output fail_count (16 bits).
- fail_count counts every mismatch, including dropped ones.
- It saturates at 16'hFFFF.
- It is cleared by rst and clr.
REQ-033 Without BIST_FAIL_LOG_COUNT_EN, port fail_count and its counter SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-034 Reset, bist_active=1, one mismatch at addr 5 with exp 8'h55, act 8'h54.
- Next cycle: log_valid=1, log_addr=5, log_exp=8'h55, log_syn=8'h01.
REQ-035 DEPTH=4, log_ready=0, 6 mismatches.
- full=1, overflow=1, the first 4 records are retained in order, fail_count=6 (macro on).
REQ-036 Full FIFO, mismatch and log_ready=1 on the same edge.
- count stays 4, overflow=0, the new record is at the tail.
REQ-037 bist_active falls with 2 records held.
- State goes to DRAIN with busy=1.
- After 2 pops, busy=0 and empty=1.
REQ-038 Matching compares only (exp=act=8'hAA), and cmp_valid mismatches while in IDLE.
- No records are logged, log_valid stays 0.
REQ-039 clr, and separately rst, asserted mid-capture with 3 records held.
- Next cycle: empty=1, overflow=0, state IDLE, fail_count=0.
